// File: rtl/input_options_alu_block.sv
// Switch-entry ALU: three level-sensitive load buttons capture A, B and an opcode
// from a shared switch bus; LEDS shows the combinational result of the stored values.
module input_options_alu_block #(
    parameter int DATA_WIDTH = 6,
    parameter int OP_WIDTH   = 6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] switches,
    input  logic [2:0]            buttons,
    output logic [DATA_WIDTH-1:0] LEDS
);

    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(6'b100000);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(6'b100010);
    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(6'b100100);
    localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(6'b100101);
    localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(6'b100110);
    localparam logic [OP_WIDTH-1:0] OP_NOR = OP_WIDTH'(6'b100111);
    localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(6'b000010);
    localparam logic [OP_WIDTH-1:0] OP_SRA = OP_WIDTH'(6'b000011);

    logic [DATA_WIDTH-1:0] reg_a_q, reg_a_d;
    logic [DATA_WIDTH-1:0] reg_b_q, reg_b_d;
    logic [OP_WIDTH-1:0]   reg_op_q, reg_op_d;
    logic [DATA_WIDTH-1:0] result;

    // Buttons are plain levels: every edge with a button held reloads its register.
    always_comb begin
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        reg_op_d = reg_op_q;
        if (buttons[2]) reg_a_d  = switches;
        if (buttons[1]) reg_b_d  = switches;
        if (buttons[0]) reg_op_d = switches[OP_WIDTH-1:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            reg_op_q <= '0;
        end else begin
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            reg_op_q <= reg_op_d;
        end
    end

    // Shifts by DATA_WIDTH or more naturally saturate to zero / sign fill.
    always_comb begin
        result = '0;
        case (reg_op_q)
            OP_ADD:  result = reg_a_q + reg_b_q;
            OP_SUB:  result = reg_a_q - reg_b_q;
            OP_AND:  result = reg_a_q & reg_b_q;
            OP_OR:   result = reg_a_q | reg_b_q;
            OP_XOR:  result = reg_a_q ^ reg_b_q;
            OP_NOR:  result = ~(reg_a_q | reg_b_q);
            OP_SRL:  result = reg_a_q >> reg_b_q;
            OP_SRA:  result = $unsigned($signed(reg_a_q) >>> reg_b_q);
            default: result = '0;
        endcase
    end

    assign LEDS = result;

endmodule

// File: tb/tb_input_options_alu_block.sv
// Directed bench for input_options_alu_block: a vector table for the ALU ops
// plus hand-written sequences for simultaneous loads, holding and async reset.
module tb_input_options_alu_block;

    logic       clock;
    logic       reset_n;
    logic [5:0] switches;
    logic [2:0] buttons;
    logic [5:0] LEDS;

    int assertCount;
    int failCount;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] op;
        logic [5:0] expected;
        string      name;
    } vec_t;

    vec_t vecs[16];

    input_options_alu_block #(.DATA_WIDTH(6), .OP_WIDTH(6)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .switches (switches),
        .buttons  (buttons),
        .LEDS     (LEDS)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [5:0] expected);
        assertCount++;
        if (LEDS !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: LEDS=%b expected %b", name, LEDS, expected);
        end
    endtask

    // Drives switches/buttons for exactly one rising edge, returning at the following negedge.
    task automatic applyStimulus(input logic [5:0] sw, input logic [2:0] btn);
        @(negedge clock);
        switches = sw;
        buttons  = btn;
        @(negedge clock);
        buttons  = 3'b000;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        switches    = 6'd0;
        buttons     = 3'b000;
        reset_n     = 1'b0;

        vecs[0]  = '{6'd25,      6'd20,      6'b100000, 6'd45,      "add_basic"};
        vecs[1]  = '{6'd50,      6'd30,      6'b100000, 6'd16,      "add_wrap"};
        vecs[2]  = '{6'd5,       6'd9,       6'b100010, 6'd60,      "sub_borrow"};
        vecs[3]  = '{6'd9,       6'd5,       6'b100010, 6'd4,       "sub_basic"};
        vecs[4]  = '{6'b101100,  6'b011010,  6'b100100, 6'b001000,  "and"};
        vecs[5]  = '{6'b101100,  6'b011010,  6'b100101, 6'b111110,  "or"};
        vecs[6]  = '{6'b101100,  6'b011010,  6'b100110, 6'b110110,  "xor"};
        vecs[7]  = '{6'b101100,  6'b011010,  6'b100111, 6'b000001,  "nor"};
        vecs[8]  = '{6'b100100,  6'd2,       6'b000010, 6'b001001,  "srl_2"};
        vecs[9]  = '{6'b100100,  6'd2,       6'b000011, 6'b111001,  "sra_2"};
        vecs[10] = '{6'b100100,  6'd7,       6'b000010, 6'b000000,  "srl_7"};
        vecs[11] = '{6'b100100,  6'd7,       6'b000011, 6'b111111,  "sra_7"};
        vecs[12] = '{6'b100100,  6'd6,       6'b000010, 6'b000000,  "srl_width"};
        vecs[13] = '{6'b010100,  6'd2,       6'b000011, 6'b000101,  "sra_positive"};
        vecs[14] = '{6'b100100,  6'd5,       6'b000011, 6'b111111,  "sra_5"};
        vecs[15] = '{6'b101100,  6'b011010,  6'b000111, 6'b000000,  "undefined_op"};

        #1;
        checkOutput("reset_before_edge", 6'd0);
        @(negedge clock);
        @(negedge clock);
        checkOutput("reset_after_edges", 6'd0);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("after_release", 6'd0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].a, 3'b100);
            applyStimulus(vecs[i].b, 3'b010);
            applyStimulus(vecs[i].op, 3'b001);
            checkOutput(vecs[i].name, vecs[i].expected);
        end

        // All three buttons at once
        applyStimulus(6'b100000, 3'b111);
        checkOutput("simul_add", 6'd0);
        applyStimulus(6'b100101, 3'b001);
        checkOutput("simul_or_shows_a_b", 6'd32);
        applyStimulus(6'b000111, 3'b001);
        checkOutput("simul_undefined", 6'd0);

        // Held button reloads every edge; released buttons hold
        applyStimulus(6'b100000, 3'b001);
        applyStimulus(6'd3, 3'b010);
        @(negedge clock);
        switches = 6'd10;
        buttons  = 3'b100;
        @(negedge clock);
        checkOutput("level_first_edge", 6'd13);
        switches = 6'd20;
        @(negedge clock);
        checkOutput("level_second_edge", 6'd23);
        buttons  = 3'b000;
        switches = 6'd63;
        @(negedge clock);
        @(negedge clock);
        checkOutput("hold_no_buttons", 6'd23);

        // Asynchronous reset mid-cycle with buttons held
        @(posedge clock);
        #2;
        switches = 6'b100101;
        buttons  = 3'b111;
        reset_n  = 1'b0;
        #1;
        checkOutput("async_reset_immediate", 6'd0);
        @(negedge clock);
        @(negedge clock);
        checkOutput("reset_overrides_buttons", 6'd0);
        buttons = 3'b000;
        reset_n = 1'b1;
        applyStimulus(6'b100101, 3'b001);
        checkOutput("regs_zero_after_reset", 6'd0);

        // First load on the first edge after release
        reset_n = 1'b0;
        @(negedge clock);
        switches = 6'b100101;
        buttons  = 3'b111;
        reset_n  = 1'b1;
        @(negedge clock);
        buttons  = 3'b000;
        checkOutput("first_load_after_release", 6'b100101);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/input_options_alu_block.md
INPUT_OPTIONS_ALU_BLOCK -- requirements
Module: input_options_ALU

Interface
- REQ-001 Parameter DATA_WIDTH, default 6: width of operands A, B, switches and LEDS.
- REQ-002 Parameter OP_WIDTH, default 6: width of the opcode register.
- REQ-003 Port clock, input, 1 bit: single system clock; all state updates on its rising edge.
- REQ-004 Port reset_n, input, 1 bit: reset; one clock; reset is asynchronous and active-low.
- REQ-005 Port switches, input, DATA_WIDTH bits: shared data/opcode entry bus.
- REQ-006 Port buttons, input, 3 bits: load strobes; bit 2 = load A, bit 1 = load B, bit 0 = load opcode.
- REQ-007 Port LEDS, output, DATA_WIDTH bits: ALU result for the currently stored A, B and opcode.

Function
- REQ-008 Internal registers SHALL be: reg_a (DATA_WIDTH), reg_b (DATA_WIDTH) and reg_op (OP_WIDTH).
- REQ-009 On each rising clock edge with buttons[2]=1, reg_a SHALL load switches.
- REQ-010 On each rising clock edge with buttons[1]=1, reg_b SHALL load switches.
- REQ-011 On each rising clock edge with buttons[0]=1, reg_op SHALL load switches[OP_WIDTH-1:0].
- REQ-012 Buttons SHALL be level-sensitive: a register reloads on every edge while its button is held; no edge detection and no debouncing.
- REQ-013 Simultaneous buttons SHALL be legal: every asserted register loads the same switches value on the same edge.
- REQ-014 With all buttons 0, the registers SHALL hold their values.
- REQ-015 LEDS SHALL be combinational from reg_a, reg_b and reg_op; it is valid right after the loading edge (latency one edge from button sample to result).
- REQ-016 Opcode 100000 ADD: LEDS = (A + B) mod 2^DATA_WIDTH; carry discarded.
- REQ-017 Opcode 100010 SUB: LEDS = (A - B) mod 2^DATA_WIDTH; borrow discarded, two's-complement wrap.
- REQ-018 Opcode 100100 AND: LEDS = A & B.
- REQ-019 Opcode 100101 OR: LEDS = A | B.
- REQ-020 Opcode 100110 XOR: LEDS = A ^ B.
- REQ-021 Opcode 100111 NOR: LEDS = ~(A | B).
- REQ-022 Opcode 000010 SRL: LEDS = A logically shifted right by the unsigned value of B, zero fill.
- REQ-023 Opcode 000011 SRA: LEDS = A arithmetically shifted right by the unsigned value of B, filling with A[DATA_WIDTH-1].
- REQ-024 Shift counts of DATA_WIDTH or more SHALL give 0 for SRL and all copies of A's MSB for SRA.
- REQ-025 Any other opcode SHALL give LEDS = 0.
- REQ-026 There SHALL be no status flags and no overflow indication.

Reset
- REQ-027 While reset_n=0, reg_a, reg_b and reg_op SHALL be 0 immediately, without waiting for a clock edge.
- REQ-028 Because reg_op=0 is an undefined opcode, LEDS SHALL be 0 during and after reset until a valid opcode is loaded.
- REQ-029 Reset SHALL override any asserted button.
- REQ-030 The first load after release SHALL occur on the first rising edge with reset_n=1 and a button asserted.

Verification
- REQ-031 Reset, then load A=25, B=20, op=100000 -> LEDS=45; then A=50, B=30 -> LEDS=16 (wrap).
- REQ-032 A=5, B=9, op=100010 -> LEDS=60 (6'b111100); A=9, B=5 -> LEDS=4.
- REQ-033 A=6'b101100, B=6'b011010: AND -> 001000; OR -> 111110; XOR -> 110110; NOR -> 000001.
- REQ-034 A=6'b100100, B=2: SRL -> 001001, SRA -> 111001; same A with B=7: SRL -> 0, SRA -> 111111.
- REQ-035 All three buttons asserted with switches=6'b100000 -> A=B=32, op=ADD, LEDS=0; then op=000111 (undefined) -> LEDS=0.
- REQ-036 Assert reset_n=0 mid-clock with a valid result on LEDS -> LEDS=0 before the next clock edge; registers hold 0 while buttons are held during reset.
